// File: rtl/down_timer.sv
// down_timer: loadable, pausable down-counting interval timer with an
// optional prescaler. Counts ticks from a loaded value down to zero, then
// either stops in DONE (one-shot) or reloads and keeps running (periodic).
// Command priority each cycle: load > stop > start > tick.
module down_timer #(
  parameter int MAX_COUNT      = 16,
  parameter int COUNTER_WIDTH  = $clog2(MAX_COUNT + 1),
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic [COUNTER_WIDTH-1:0] i_load_value,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_reload_en,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_expired
);

  // Reject parameter sets the counter cannot represent.
  if (MAX_COUNT <= 0) begin : g_chk_max
    $fatal(1, "down_timer: MAX_COUNT must be > 0");
  end
  if (PRESCALE < 1) begin : g_chk_pre
    $fatal(1, "down_timer: PRESCALE must be >= 1");
  end
  if ((64'd1 << COUNTER_WIDTH) <= 64'(MAX_COUNT)) begin : g_chk_w
    $fatal(1, "down_timer: COUNTER_WIDTH too small for MAX_COUNT");
  end

  localparam logic [COUNTER_WIDTH-1:0]  CNT_MAX  = COUNTER_WIDTH'(MAX_COUNT);
  localparam logic [COUNTER_WIDTH-1:0]  CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_LAST  = PRESCALE_WIDTH'(PRESCALE - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [COUNTER_WIDTH-1:0]  count_q, count_d;
  logic [COUNTER_WIDTH-1:0]  reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      expired_q, expired_d;

  logic [COUNTER_WIDTH-1:0]  load_sat;
  logic                      tick;

  // Clamp the requested load value so the count never exceeds MAX_COUNT.
  assign load_sat = (i_load_value > CNT_MAX) ? CNT_MAX : i_load_value;
  // The prescaler's last phase is the cycle a tick lands on (always, when PRESCALE=1).
  assign tick     = (presc_q == PS_LAST);

  // State and datapath registers; reset aborts any run without an expiry pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic: resolve the highest-priority command, else advance a tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    if (i_load) begin
      count_d  = load_sat;
      reload_d = load_sat;
      presc_d  = '0;
      state_d  = S_IDLE;
    end else if (i_stop) begin
      // Pause keeps count and prescaler phase so a later start resumes exactly.
      if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (i_start && (state_q != S_RUN)) begin
      if (state_q == S_IDLE) begin
        if (count_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d   = S_DONE;
          expired_d = 1'b1;
        end
      end else begin
        // Retrigger from DONE restarts a full period from the reload value.
        count_d = reload_q;
        presc_d = '0;
        if (reload_q != '0) begin
          state_d = S_RUN;
        end else begin
          expired_d = 1'b1;
        end
      end
    end else if (state_q == S_RUN) begin
      // A start while running is ignored, so ticking continues undisturbed.
      if (tick) begin
        presc_d = '0;
        if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else if (i_reload_en) begin
          count_d   = reload_q;
          expired_d = 1'b1;
        end else begin
          count_d   = '0;
          state_d   = S_DONE;
          expired_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PS_ONE;
      end
    end
  end

  assign o_count   = count_q;
  assign o_busy    = (state_q == S_RUN);
  assign o_done    = (state_q == S_DONE);
  assign o_expired = expired_q;

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, pausable down-counting timer with an optional prescaler. It is the count-down counterpart to the saturating up-counter.
- Used for MIL-1553 interval timing: response-timeout, inter-message gap and bus-idle timers.
- Counts ticks from a loaded value to zero, then flags expiry.
- One-shot or auto-reload (periodic) mode.

Parameters:
- MAX_COUNT, 16: largest loadable value; must be > 0.
- COUNTER_WIDTH, $clog2(MAX_COUNT+1): width of count and load value.
- PRESCALE, 1: i_clk cycles per timer tick; must be >= 1.
- PRESCALE_WIDTH, $clog2(PRESCALE+1): width of the internal prescaler counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load  in  1  single-cycle load strobe.
- i_load_value  in  COUNTER_WIDTH  value captured on i_load.
- i_start  in  1  start, resume or retrigger strobe.
- i_stop  in  1  pause strobe.
- i_reload_en  in  1  auto-reload mode, sampled at each expiry.
- o_count  out  COUNTER_WIDTH  current remaining ticks.
- o_busy  out  1  high in RUN.
- o_done  out  1  high in DONE.
- o_expired  out  1  one-cycle registered pulse at each expiry.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, count=0, reload register=0, prescaler=0, o_expired=0. Therefore o_busy=0, o_done=0, o_count=0. Reset mid-run aborts immediately with no expiry pulse.
- States: IDLE (stopped or paused), RUN, DONE. o_busy=(state==RUN), o_done=(state==DONE); both are combinational from state.
- Command priority per cycle: i_load > i_stop > i_start > tick.
- i_load, any state:
  - Captures min(i_load_value, MAX_COUNT) into both count and the reload register.
  - Clears the prescaler; state -> IDLE.
  - Any tick or expiry due in that cycle is suppressed.
- i_stop:
  - In RUN: state -> IDLE; count and prescaler are held (pause).
  - In IDLE or DONE: no effect.
- i_start:
  - IDLE with count>0: -> RUN, resuming from the held count and prescaler.
  - IDLE with count==0: -> DONE and o_expired=1 on the next cycle.
  - DONE: count <= reload register, prescaler <= 0, -> RUN (retrigger). If the reload register is 0: stay DONE and pulse o_expired.
  - RUN: ignored.
- Tick (RUN only):
  - Prescaler increments every cycle; when it equals PRESCALE-1 it wraps to 0 and a tick occurs.
  - With PRESCALE=1, every RUN cycle is a tick.
  - Tick with count>1: count <= count-1.
  - Tick with count==1, i_reload_en=0: count <= 0, -> DONE, o_expired=1 for one cycle (coincident with count becoming 0).
  - Tick with count==1, i_reload_en=1: count <= reload register, stay RUN, o_expired=1 for one cycle. Period = reload value × PRESCALE cycles.
- Latency: i_start at edge N puts the block in RUN after edge N. The first decrement is visible after edge N+PRESCALE. With a loaded value L, expiry is visible after edge N+L×PRESCALE.
- Count never wraps below 0 and never exceeds MAX_COUNT.
- DONE holds count=0 until load or start.
- o_expired is never asserted for two consecutive cycles when PRESCALE>1. With PRESCALE=1 and reload=1 it may stay high continuously.
- Elaboration checks (fatal):
  - MAX_COUNT>0.
  - PRESCALE>=1.
  - 2**COUNTER_WIDTH > MAX_COUNT.

Test Plan:
- MAX_COUNT=16, PRESCALE=1; load 5, start next cycle -> o_count 4,3,2,1,0 on 5 consecutive cycles. o_expired high only in the cycle count=0; o_done stays high after; o_busy low after.
- Auto-reload, i_reload_en=1, load 3, start -> o_expired pulses every 3 cycles for 4 periods. o_busy stays 1; o_count cycles 2,1,3,2,1,3…
- Pause: load 6, start, stop after 2 ticks (count=4), wait 5 cycles -> count stays 4. Start -> expiry 4 cycles later. Load during RUN -> IDLE with the new value, no expiry.
- Boundaries:
  - load 20 -> o_count=16.
  - load 0, start -> o_done=1, one o_expired pulse.
  - In DONE after load 3, start -> retrigger to 3 and expire 3 cycles later.
  - Load and start in the same cycle -> load wins, state IDLE.
- PRESCALE=4: load 2, start -> count 1 after 4 cycles, expiry after 8 cycles. Async reset asserted mid-run (count=1) -> outputs zero immediately with no o_expired.
